ni_flit_receiver: RTL
=====================

// Module: ni_flit_receiver
// PURPOSE
//  Network-interface receive stage directly downstream of a 3-input router output port.
//  Consumes 16-bit flits over the req/bussy handshake.
//  Reassembles one packet (head + payload flits) into a local buffer.
//  Replays the payload word-by-word to the attached PE over a valid/ready interface,
//  tagged with its priority class.
// PARAMETERS
//  MAX_LEN  8  max payload flits per packet, legal range 1..15
//  PTR_W    3  buffer index width, must satisfy 2**PTR_W >= MAX_LEN
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  in_req     in   1   upstream flit valid
//  in_data    in   16  upstream flit
//  in_bussy   out  1   1 = flit not accepted this cycle
//  pe_valid   out  1   payload word valid to PE
//  pe_data    out  13  payload word
//  pe_last    out  1   marks final payload word of packet
//  pe_prio    out  1   1 = packet arrived with priority head
//  pe_ready   in   1   PE accepts word
//  err_pulse  out  1   one-cycle pulse on any protocol error
//  err_cnt    out  8   saturating protocol error count
// BEHAVIOUR
//  Flit format: [15:13] type; [12:0] payload.
//    Type 000 = regular head, 001 = priority head, 010 = payload, others illegal.
//    Head [3:0] = LEN, the number of payload flits that follow.
//  Transfer rule: a flit is consumed on a rising edge with in_req=1 and in_bussy=0.
//    in_bussy is a function of state only, never of in_req.
//  Reset (rst=0, immediate): state=IDLE, in_bussy=1, pe_valid=0, pe_last=0, pe_prio=0,
//    pe_data=0, err_pulse=0, err_cnt=0, pointers=0.
//    Reset mid-packet discards the partial packet.
//    in_bussy drops to 0 on the first clock edge after release.
//  FSM states: IDLE, RECV, SEND.
//  IDLE, in_bussy=0:
//    Head with 1<=LEN<=MAX_LEN: latch LEN, latch prio=type[0], wr_ptr=0, go to RECV.
//    Head with LEN=0 or LEN>MAX_LEN: dropped, error, stay in IDLE.
//    Payload or illegal type: dropped, error, stay in IDLE.
//  RECV, in_bussy=0:
//    Payload flit: buf[wr_ptr]=in_data[12:0], wr_ptr++.
//    When the LEN-th payload flit is written, go to SEND on the next edge.
//    Legal head: error; the partial packet is abandoned.
//      The new head is processed as in IDLE and restarts RECV.
//    Illegal type: dropped, error, stay in RECV with wr_ptr unchanged.
//    No req: hold, no timeout.
//  SEND, in_bussy=1:
//    pe_valid=1, pe_data=buf[rd_ptr], pe_prio=latched prio, pe_last=(rd_ptr==LEN-1).
//    On pe_valid & pe_ready: rd_ptr++.
//    On the last word: go to IDLE.
//      pe_valid=0 and in_bussy=0 on the following cycle.
//    pe_data, pe_last and pe_prio stay stable while pe_valid=1 and pe_ready=0.
//  Latency: last payload flit consumed at edge t -> pe_valid=1 after edge t+1.
//    Throughput is then one word per cycle with pe_ready held at 1.
//  Errors: err_pulse=1 for exactly the cycle after the offending edge.
//    err_cnt increments by 1 per error and saturates at 255, with no wrap.
//  Outputs are registered; there is no combinational path from in_* to pe_*.
// TESTING
//  Regular head 0x0003, payloads 0x4011,0x4022,0x4033, pe_ready=1:
//    pe_data 0x0011,0x0022,0x0033 on 3 consecutive cycles.
//    pe_last only on 0x0033; pe_prio=0.
//  Priority head 0x2002, 2 payloads, pe_ready low 4 cycles:
//    words held stable, pe_prio=1, in_bussy=1 throughout SEND.
//    After the last word, in_bussy=0 one cycle later.
//  Payload 0x4005 in IDLE, then head with LEN=0, then head with LEN=9 (MAX_LEN=8):
//    3 err_pulses, err_cnt=3, no pe_valid.
//  Head LEN=4, 2 payloads, then a new head LEN=1 and 1 payload:
//    err_cnt+1, PE sees only the single-word packet.
//  rst low for 1 cycle during RECV or SEND:
//    pe_valid=0 immediately.
//    A subsequent clean 1-flit packet delivers correctly.
//  300 illegal-type flits (0xE000) in IDLE: err_cnt saturates at 255.

Source files
------------

// File: rtl/ni_flit_receiver.sv
// Network-interface receive stage: reassembles one head+payload packet from the
// router req/bussy link and replays its payload to the PE over valid/ready.
module ni_flit_receiver #(
  parameter int MAX_LEN = 8,
  parameter int PTR_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req,
  input  logic [15:0] in_data,
  output logic        in_bussy,
  output logic        pe_valid,
  output logic [12:0] pe_data,
  output logic        pe_last,
  output logic        pe_prio,
  input  logic        pe_ready,
  output logic        err_pulse,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** PTR_W;

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_nxt;
  logic [3:0]         len_m1;
  logic               prio;
  logic [12:0]        buf_mem [DEPTH];

  logic [2:0]         flit_type;
  logic [3:0]         head_len;
  logic               is_head;
  logic               is_pay;
  logic               len_ok;
  logic               accept;
  logic               err_now;
  logic               wr_last;
  logic               rd_last;
  logic               nxt_last;

  assign flit_type = in_data[15:13];
  assign head_len  = in_data[3:0];
  assign is_head   = (flit_type == 3'b000) || (flit_type == 3'b001);
  assign is_pay    = (flit_type == 3'b010);
  assign len_ok    = (head_len != 4'd0) && (32'(head_len) <= MAX_LEN);
  assign accept    = in_req && !in_bussy;
  assign rd_nxt    = rd_ptr + PTR_W'(1);
  assign wr_last   = (32'(wr_ptr) == 32'(len_m1));
  assign rd_last   = (32'(rd_ptr) == 32'(len_m1));
  assign nxt_last  = (32'(rd_nxt) == 32'(len_m1));

  // Any non-payload flit while receiving is an error; a head also abandons the packet.
  assign err_now = accept &&
                   (((state == IDLE) && !(is_head && len_ok)) ||
                    ((state == RECV) && !is_pay));

  always_ff @(posedge clk) begin
    if ((state == RECV) && accept && is_pay) begin
      buf_mem[wr_ptr] <= in_data[12:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_bussy <= 1'b1;
      pe_valid <= 1'b0;
      pe_data  <= '0;
      pe_last  <= 1'b0;
      pe_prio  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      len_m1   <= '0;
      prio     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_bussy <= 1'b0;
          if (accept && is_head && len_ok) begin
            len_m1 <= head_len - 4'd1;
            prio   <= in_data[13];
            wr_ptr <= '0;
            state  <= RECV;
          end
        end

        RECV: begin
          if (accept) begin
            if (is_pay) begin
              if (wr_last) begin
                state    <= SEND;
                in_bussy <= 1'b1;
                rd_ptr   <= '0;
              end else begin
                wr_ptr <= wr_ptr + PTR_W'(1);
              end
            end else if (is_head && len_ok) begin
              len_m1 <= head_len - 4'd1;
              prio   <= in_data[13];
              wr_ptr <= '0;
            end else if (is_head) begin
              state <= IDLE;
            end
          end
        end

        SEND: begin
          // First SEND cycle only loads word 0; afterwards advance on each handshake.
          if (!pe_valid) begin
            pe_valid <= 1'b1;
            pe_data  <= buf_mem[rd_ptr];
            pe_last  <= rd_last;
            pe_prio  <= prio;
          end else if (pe_ready) begin
            if (pe_last) begin
              pe_valid <= 1'b0;
              pe_last  <= 1'b0;
              in_bussy <= 1'b0;
              rd_ptr   <= '0;
              state    <= IDLE;
            end else begin
              rd_ptr  <= rd_nxt;
              pe_data <= buf_mem[rd_nxt];
              pe_last <= nxt_last;
            end
          end
        end

        default: begin
          state    <= IDLE;
          in_bussy <= 1'b0;
          pe_valid <= 1'b0;
          pe_last  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_pulse <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      err_pulse <= err_now;
      if (err_now && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
